// File: rtl/alu_sseg_display.sv
// alu_sseg_display
//   Display stage for the ALU. It captures result/status/op_code on a one-cycle
//   load strobe and drives a 4-digit, time-multiplexed, common-anode seven-segment
//   display. Digit 0/1 show the result in hex (digit 1 only when WIDTH > 4),
//   digit 2 is blank, and digit 3 shows an opcode symbol. The decimal point of
//   digit 0 shows the captured status flag.
//
//   Optional feature macro: SSEG_STATUS_BLINK_EN. When it is defined, the whole
//   display blinks while the captured status is 1. Each half-period lasts
//   BLINK_FRAMES full scan frames.
//
// Parameters
//   WIDTH         ALU result width, 1..8. The result is zero-extended to 8 bits.
//   REFRESH_DIV   Number of clk cycles each digit stays lit (>= 2).
//   BLINK_FRAMES  Scan frames per blink half-period (blink build only).
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset (wins over load)
//   load     in   capture strobe for result/status/op_code
//   result   in   [WIDTH-1:0] ALU result
//   status   in   ALU status flag
//   op_code  in   [1:0] 00 add, 01 sub, 10 and, 11 xor
//   an_n     out  [3:0] digit enables, active-low, one-hot-low
//   seg_n    out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp_n     out  decimal point, active-low
module alu_sseg_display #(
  parameter int WIDTH        = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] result,
  input  logic             status,
  input  logic [1:0]       op_code,
  output logic [3:0]       an_n,
  output logic [6:0]       seg_n,
  output logic             dp_n
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Illegal parameter values are caught at elaboration time.
  if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
    $error("alu_sseg_display: WIDTH must be 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("alu_sseg_display: REFRESH_DIV must be >= 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_frames
    $error("alu_sseg_display: BLINK_FRAMES must be >= 1");
  end

  // Segment encoders, active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] op_to_seg(input logic [1:0] op);
    logic [6:0] s;
    case (op)
      2'b00: s = 7'h08;   // 'A'
      2'b01: s = 7'h3F;   // '-'
      2'b10: s = 7'h2B;   // 'n'
      default: s = 7'h09; // 'H'
    endcase
    return s;
  endfunction

  // ---- stage p0: captured operands and scan position ----
  logic [7:0]       res_p0;
  logic [1:0]       op_p0;
  logic             stat_p0;
  logic             vld_p0;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic [7:0] res_ext;
  logic       digit_end;
  logic       frame_end;

  assign res_ext   = 8'(result);
  assign digit_end = (cnt == CNT_MAX);
  assign frame_end = digit_end && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      res_p0  <= '0;
      op_p0   <= '0;
      stat_p0 <= 1'b0;
      vld_p0  <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
    end else begin
      if (load) begin
        res_p0  <= res_ext;
        op_p0   <= op_code;
        stat_p0 <= status;
        vld_p0  <= 1'b1;
      end
      if (digit_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Blink phase: counts completed frames since the last load and toggles the
  // phase every BLINK_FRAMES frames. A load restarts the blink cycle so that a
  // fresh result is always visible first.
  logic blank;
`ifdef SSEG_STATUS_BLINK_EN
  localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_MAX = FR_W'(BLINK_FRAMES - 1);

  logic [FR_W-1:0] frame_cnt;
  logic            phase;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FR_MAX) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FR_W'(1);
      end
    end
  end

  assign blank = stat_p0 && phase;
`else
  assign blank = 1'b0;
`endif

  logic [6:0] seg_d;
  logic       dp_d;
  logic [3:0] an_d;

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (vld_p0) begin
      case (idx)
        2'd0: seg_d = hex_to_seg(res_p0[3:0]);
        2'd1: seg_d = (WIDTH > 4) ? hex_to_seg(res_p0[7:4]) : SEG_BLANK;
        2'd3: seg_d = op_to_seg(op_p0);
        default: seg_d = SEG_BLANK;
      endcase
      if (idx == 2'd0 && stat_p0) dp_d = 1'b0;
    end
  end

  // Blanking only releases the anodes; segments and the scan keep running.
  assign an_d = blank ? 4'hF : ~(4'b0001 << idx);

  // ---- stage p1: registered display drive ----
  always_ff @(posedge clk) begin
    if (rst) begin
      an_n  <= 4'hF;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_d;
      seg_n <= seg_d;
      dp_n  <= dp_d;
    end
  end

  // Bits of frame_end are only consumed by the blink logic.
  logic unused_ok;
  assign unused_ok = frame_end;

endmodule

// File: tb/tb_alu_sseg_display.sv
module tb_alu_sseg_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] result = 4'h0;
  logic       status = 1'b0;
  logic [1:0] op_code = 2'b00;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  alu_sseg_display #(
    .WIDTH(4),
    .REFRESH_DIV(4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .result(result),
    .status(status),
    .op_code(op_code),
    .an_n(an_n),
    .seg_n(seg_n),
    .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference timing state as it stands before the next clock edge.
  int         r_cnt = 0;
  int         r_idx = 0;
  bit         r_valid = 1'b0;
  bit         r_stat = 1'b0;
  bit         r_phase = 1'b0;
  int         r_frames = 0;
  logic [6:0] r_seg [4];
  // Hand-computed digit codes for the vector being loaded.
  logic [6:0] p_seg [4];

  // Advance one clock edge and check all outputs against the expectation
  // formed from the pre-edge state and the inputs presented at that edge.
  task automatic step(input string tag);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    if (rst) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << r_idx);
      e_seg = r_valid ? r_seg[r_idx] : 7'h7F;
      e_dp  = !(r_idx == 0 && r_valid && r_stat);
`ifdef SSEG_STATUS_BLINK_EN
      if (r_stat && r_phase) e_an = 4'hF;
`endif
    end

    if (rst) begin
      r_cnt = 0; r_idx = 0; r_valid = 0; r_stat = 0; r_phase = 0; r_frames = 0;
    end else begin
      if (r_cnt == 3) begin
        r_cnt = 0;
        if (r_idx == 3) begin
          r_idx = 0;
          r_frames++;
          if (r_frames == 2) begin
            r_frames = 0;
            r_phase = !r_phase;
          end
        end else begin
          r_idx++;
        end
      end else begin
        r_cnt++;
      end
      if (load) begin
        r_valid = 1'b1;
        r_stat = status;
        r_seg = p_seg;
        r_phase = 1'b0;
        r_frames = 0;
      end
    end

    @(posedge clk);
    #1;
    checks++;
    assert (an_n === e_an) else begin
      errors++;
      $error("FAIL %s an_n: got %h expected %h", tag, an_n, e_an);
    end
    checks++;
    assert (seg_n === e_seg) else begin
      errors++;
      $error("FAIL %s seg_n: got %h expected %h", tag, seg_n, e_seg);
    end
    checks++;
    assert (dp_n === e_dp) else begin
      errors++;
      $error("FAIL %s dp_n: got %b expected %b", tag, dp_n, e_dp);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_load(input string tag, input logic [3:0] res, input logic [1:0] op,
                         input logic st, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
    result  = res;
    op_code = op;
    status  = st;
    p_seg[0] = s0; p_seg[1] = s1; p_seg[2] = s2; p_seg[3] = s3;
    load = 1'b1;
    step(tag);
    load = 1'b0;
    // Inputs are junk while load=0 and must be ignored.
    result  = ~res;
    op_code = ~op;
    status  = ~st;
  endtask

  initial begin
    #1;
    // Reset held for 3 cycles: display fully dark.
    run("reset", 3);
    rst = 1'b0;

    // Unloaded scan: an_n walks E,D,B,7,E with blank segments, 4 cycles each.
    run("idle_scan", 20);

    // add, result A, status 0: digit0 'A', digit3 'A'.
    do_load("load_add", 4'hA, 2'b00, 1'b0, 7'h08, 7'h7F, 7'h7F, 7'h08);
    run("add_scan", 32);

    // sub, result 0, status 1: digit0 '0' with dp lit, digit3 '-'.
    // Running 5 frames covers the blink off/on transitions when enabled.
    do_load("load_sub", 4'h0, 2'b01, 1'b1, 7'h40, 7'h7F, 7'h7F, 7'h3F);
    run("sub_scan", 80);

    // Back-to-back loads: the last one wins (and 'n' F, status kept as is).
    do_load("load_b2b0", 4'h5, 2'b11, 1'b0, 7'h12, 7'h7F, 7'h7F, 7'h09);
    do_load("load_b2b1", 4'hF, 2'b10, 1'b1, 7'h0E, 7'h7F, 7'h7F, 7'h2B);
    run("and_scan", 40);

    // Walk into the second half-period, then load status 0 mid-blank.
    for (int i = 0; i < 64 && !(r_phase && r_idx == 1); i++) step("to_blank");
    do_load("load_xor", 4'hC, 2'b11, 1'b0, 7'h46, 7'h7F, 7'h7F, 7'h09);
    run("xor_scan", 70);

    // Status is shown as captured even for a non-sub opcode.
    do_load("load_add_st", 4'h9, 2'b00, 1'b1, 7'h10, 7'h7F, 7'h7F, 7'h08);
    run("add_st_scan", 20);

    // Reset at digit 2 with valid data, then stay blank until a load.
    for (int i = 0; i < 16 && r_idx != 2; i++) step("to_idx2");
    rst = 1'b1;
    step("mid_reset");
    rst = 1'b0;
    run("post_reset", 20);

    // Load together with reset: reset wins, display stays blank.
    rst = 1'b1;
    result = 4'h3; op_code = 2'b01; status = 1'b1; load = 1'b1;
    step("rst_load");
    rst = 1'b0; load = 1'b0;
    run("post_rst_load", 20);

    // Recovers normally on the next load.
    do_load("load_final", 4'h7, 2'b01, 1'b0, 7'h78, 7'h7F, 7'h7F, 7'h3F);
    run("final_scan", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
